seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. It sits directly downstream of the display-source selector and takes the selected 32-bit word as eight hex nibbles. It scans one digit at a time at a divided refresh rate and drives active-low anode and segment lines. The displayed word is latched once per scan frame, so a value that changes mid-scan never shows a mix of old and new digits.

## Interface
Parameters:
- `DIV`, default 100000: clk cycles per digit slot; legal range 1 to 2^24. Divider width is clog2(DIV), minimum 1.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous and active-high.
- `value`  in  32  word to display; nibble i appears on digit i, with digit 0 rightmost.
- `dp_mask`  in  8  bit i = 1 lights the decimal point of digit i. Sampled live, not frame-latched.
- `AN`  out  8  anodes, active low; bit i selects digit i.
- `SEG`  out  8  segments, active low. SEG[0]=a … SEG[6]=g, SEG[7]=dp.

## Operation
- **Divider.** `div_cnt` counts 0..DIV-1 and wraps to 0. `tick` = (`div_cnt` == DIV-1). With DIV=1, `tick` is high every cycle.
- **Digit index.** `digit_idx` (3 bits) increments on `tick` and wraps 7→0.
- **Frame register.** `frame` (32 bits) loads `value` in two cases:
  - when `tick` is high and `digit_idx` == 7, i.e. at the start of a new frame;
  - in the first cycle after `rst` deasserts, driven by an `init` flag that reset sets and the load clears.
  - At all other times `frame` holds.
- **Output register.** Each cycle, `AN` and `SEG` register a decode of the current `digit_idx`, `frame` and `dp_mask`:
  - `AN` = ~(1 << `digit_idx`).
  - `SEG[6:0]` is the active-low hex glyph of nibble `frame[4*digit_idx+3 : 4*digit_idx]`:
    - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
    - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - `SEG[7]` = ~`dp_mask[digit_idx]`.
- **Reset state.**
  - `div_cnt` = 0, `digit_idx` = 0, `frame` = 0, `init` = 1.
  - `AN` = FF, `SEG` = FF (all dark).
- **Reset mid-scan.** Asserting `rst` at any point returns all state to the reset values on the next edge. No partial frame survives.

## Timing
- `AN` and `SEG` lag `digit_idx` and `frame` by one cycle.
- **After reset deasserts:**
  - cycle 1 edge: `frame` ← `value`; outputs show digit 0 of the old `frame` (0), i.e. AN=FE, SEG=C0 with dp off.
  - cycle 2: outputs show digit 0 of the newly loaded value.
- Each digit is held for DIV cycles, so one full frame takes 8·DIV cycles.
- **Frame latency.** A change on `value` appears on every digit within at most 8·DIV+1 cycles. It never appears on some digits before others within one frame.
- `dp_mask` reaches `SEG[7]` with one cycle of latency.
- **Simultaneous events.** If `init` and a frame-start `tick` coincide, a single load occurs.

## Configuration
- Macro: `SEG7_BLANK_LEADING_ZEROS_EN`.
- **Defined:** digit i (1..7) is blanked when `frame` nibbles i..7 are all zero.
  - A blanked digit drives `AN` = FF and `SEG` = FF for its slot; its dp is suppressed too.
  - Digit 0 is never blanked.
- **Undefined:** all eight digits are always driven, including leading zeros.

## Test plan
1. `rst` held 3 cycles with DIV=4 → AN=FF, SEG=FF. First cycle after release → AN=FE, SEG=C0. Next cycle → digit 0 of `value`.
2. DIV=4, `value`=76543210, dp_mask=00 → AN walks FE, FD, FB … 7F, 4 cycles each. SEG walks C0, F9, A4, B0, 99, 92, 82, F8. Sequence repeats every 32 cycles.
3. DIV=4, `value` switched from 76543210 to FFFFFFFF while digit 3 is active → digits 4–7 still show 4–7. The next frame shows 8E on all digits.
4. dp_mask=01, digit 0 active → SEG[7]=0 on digit 0 only; all other digits keep SEG[7]=1.
5. `rst` pulsed for 1 cycle while digit 5 is active → AN=FF, SEG=FF on the next edge. Scan restarts at digit 0 with a fresh frame load.
6. With `SEG7_BLANK_LEADING_ZEROS_EN`, `value`=000000A0 → digit 0 shows C0, digit 1 shows 88, digits 2–7 show AN=FF, SEG=FF. With `value`=00000000, only digit 0 lights, showing C0.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Display bus between the source selector and the seven-segment scan driver.
// The source side drives the word and dp mask; the driver returns AN and SEG.
interface seg7_scan_driver_if;
  logic [31:0] value;
  logic [7:0]  dp_mask;
  logic [7:0]  AN;
  logic [7:0]  SEG;

  modport master (output value, output dp_mask, input AN, input SEG);
  modport slave  (input value, input dp_mask, output AN, output SEG);
endinterface

// File: rtl/seg7_scan_driver.sv
// 8-digit common-anode seven-segment scan driver with a frame-latched word.
// Optional leading-zero blanking is built when SEG7_BLANK_LEADING_ZEROS_EN is defined.
module seg7_scan_driver #(
  parameter int unsigned DIV = 100000
) (
  input logic          clk,
  input logic          rst,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_div_cnt;
  logic [2:0]   r_digit_idx;
  logic [31:0]  r_frame;
  logic         r_init;
  logic [7:0]   r_an;
  logic [7:0]   r_seg;

  logic         w_tick;
  logic         w_frame_start;
  logic [4:0]   w_shift;
  logic [3:0]   w_nib;
  logic [6:0]   w_glyph;
  logic         w_blank;

  assign w_tick        = (r_div_cnt == LAST);
  assign w_frame_start = w_tick && (r_digit_idx == 3'd7);
  assign w_shift       = {r_digit_idx, 2'b00};
  assign w_nib         = r_frame[w_shift +: 4];

`ifdef SEG7_BLANK_LEADING_ZEROS_EN
  logic [31:0] w_upper;
  assign w_upper = r_frame >> w_shift;
  // digit 0 always lights so an all-zero word still shows "0"
  assign w_blank = (r_digit_idx != 3'd0) && (w_upper == 32'd0);
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_glyph = 7'h7F;
    case (w_nib)
      4'h0: w_glyph = 7'h40;
      4'h1: w_glyph = 7'h79;
      4'h2: w_glyph = 7'h24;
      4'h3: w_glyph = 7'h30;
      4'h4: w_glyph = 7'h19;
      4'h5: w_glyph = 7'h12;
      4'h6: w_glyph = 7'h02;
      4'h7: w_glyph = 7'h78;
      4'h8: w_glyph = 7'h00;
      4'h9: w_glyph = 7'h10;
      4'hA: w_glyph = 7'h08;
      4'hB: w_glyph = 7'h03;
      4'hC: w_glyph = 7'h46;
      4'hD: w_glyph = 7'h21;
      4'hE: w_glyph = 7'h06;
      4'hF: w_glyph = 7'h0E;
      default: w_glyph = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt   <= '0;
      r_digit_idx <= 3'd0;
      r_frame     <= 32'd0;
      r_init      <= 1'b1;
      r_an        <= 8'hFF;
      r_seg       <= 8'hFF;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + W'(1);
      if (w_tick)
        r_digit_idx <= r_digit_idx + 3'd1;
      // init and frame start can coincide; either way it is one load
      if (r_init || w_frame_start)
        r_frame <= bus.value;
      r_init <= 1'b0;
      if (w_blank) begin
        r_an  <= 8'hFF;
        r_seg <= 8'hFF;
      end else begin
        r_an  <= ~(8'd1 << r_digit_idx);
        r_seg <= {~bus.dp_mask[r_digit_idx], w_glyph};
      end
    end
  end

  assign bus.AN  = r_an;
  assign bus.SEG = r_seg;

endmodule
